// File: rtl/fp_mul_seq.sv
// fp_mul_seq: sequential IEEE-754 single-precision multiplier.
// A shift-add datapath consumes BITS_PER_CYCLE multiplier bits per MUL cycle,
// then one ROUND cycle normalises, rounds to nearest even and classifies.
// Valid/ready handshake on both sides; one operation in flight at a time.
// Optional feature: define FP_MUL_INEXACT_EN to add the registered 'inexact' output.
module fp_mul_seq #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] opd1,
  input  logic [31:0] opd2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] res,
  output logic        exp_overflow,
  output logic        nan,
  output logic        zero
`ifdef FP_MUL_INEXACT_EN
  ,
  output logic        inexact
`endif
);

  localparam int N  = 24 / BITS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, MUL, ROUND, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] op1_q, op2_q;
  logic [47:0] mcand_q;
  logic [23:0] mplier_q;
  logic [47:0] acc_q;
  logic [CW-1:0] cnt_q;
  logic [31:0] res_q, res_d;
  logic        ovf_q, ovf_d;
  logic        nan_q, nan_d;
  logic        zero_q, zero_d;
  logic        out_valid_q;

  // Partial product for the current group of multiplier bits.
  logic [47:0] pp_term [BITS_PER_CYCLE];
  logic [47:0] pp;

  for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_pp
    assign pp_term[gi] = mplier_q[gi] ? (mcand_q << gi) : 48'd0;
  end

  // Sum the per-bit shifted multiplicands for this cycle.
  always_comb begin
    pp = '0;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      pp = pp + pp_term[k];
    end
  end

  // Next-state logic; leaves DONE only once the result has been presented and taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (in_valid) state_d = MUL;
      MUL:   if (cnt_q == CW'(N - 1)) state_d = ROUND;
      ROUND: state_d = DONE;
      DONE:  if (out_valid_q && out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Operand classification, normalisation and rounding of the finished product.
  logic [7:0]  e1, e2;
  logic        nan1, nan2, inf1, inf2, zero1, zero2;
  logic        is_nan, zero_op, inf_op, sign;
  logic signed [9:0] exp_sum, e_norm, e_fin;
  logic [22:0] mant_raw;
  logic        guard, sticky, round_up;
  logic [23:0] mant_inc;
  logic        underflow, overflow;

  always_comb begin
    e1      = op1_q[30:23];
    e2      = op2_q[30:23];
    nan1    = (e1 == 8'hFF) && (op1_q[22:0] != 23'd0);
    nan2    = (e2 == 8'hFF) && (op2_q[22:0] != 23'd0);
    inf1    = (e1 == 8'hFF) && (op1_q[22:0] == 23'd0);
    inf2    = (e2 == 8'hFF) && (op2_q[22:0] == 23'd0);
    zero1   = (e1 == 8'd0);
    zero2   = (e2 == 8'd0);
    is_nan  = nan1 | nan2 | (inf1 & zero2) | (zero1 & inf2);
    zero_op = zero1 | zero2;
    inf_op  = inf1 | inf2;
    sign    = op1_q[31] ^ op2_q[31];

    exp_sum = $signed({2'b00, e1}) + $signed({2'b00, e2}) - 10'sd127;
    if (acc_q[47]) begin
      mant_raw = acc_q[46:24];
      guard    = acc_q[23];
      sticky   = |acc_q[22:0];
      e_norm   = exp_sum + 10'sd1;
    end else begin
      mant_raw = acc_q[45:23];
      guard    = acc_q[22];
      sticky   = |acc_q[21:0];
      e_norm   = exp_sum;
    end
    round_up  = guard & (sticky | mant_raw[0]);
    // A carry out of the 23-bit field only happens from all-ones, leaving zeros behind.
    mant_inc  = {1'b0, mant_raw} + {23'd0, round_up};
    e_fin     = e_norm + (mant_inc[23] ? 10'sd1 : 10'sd0);
    underflow = (e_fin <= 10'sd0);
    overflow  = (e_fin >= 10'sd255);

    res_d  = {sign, e_fin[7:0], mant_inc[22:0]};
    ovf_d  = 1'b0;
    nan_d  = 1'b0;
    zero_d = 1'b0;
    if (is_nan) begin
      res_d = 32'h7F80_0001;
      nan_d = 1'b1;
    end else if (zero_op || underflow) begin
      res_d  = 32'h0000_0000;
      zero_d = 1'b1;
    end else if (inf_op || overflow) begin
      res_d = {sign, 8'hFF, 23'h0};
      ovf_d = 1'b1;
    end
  end

  // Datapath: capture operands on accept, accumulate in MUL, register the result in ROUND.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op1_q    <= '0;
      op2_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
      ovf_q    <= 1'b0;
      nan_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          op1_q    <= opd1;
          op2_q    <= opd2;
          mcand_q  <= {24'd0, 1'b1, opd1[22:0]};
          mplier_q <= {1'b1, opd2[22:0]};
          acc_q    <= '0;
          cnt_q    <= '0;
        end
        MUL: begin
          acc_q    <= acc_q + pp;
          mcand_q  <= mcand_q << BITS_PER_CYCLE;
          mplier_q <= mplier_q >> BITS_PER_CYCLE;
          cnt_q    <= cnt_q + CW'(1);
        end
        ROUND: begin
          res_q  <= res_d;
          ovf_q  <= ovf_d;
          nan_q  <= nan_d;
          zero_q <= zero_d;
        end
        default: ;
      endcase
    end
  end

  // out_valid comes straight from a flop, raised one cycle after entering DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_valid_q <= 1'b0;
    else     out_valid_q <= (state_q == DONE) && !(out_valid_q && out_ready);
  end

`ifdef FP_MUL_INEXACT_EN
  logic inexact_q, inexact_d;

  // Inexact: lost bits of a normal result, or overflow/underflow from finite non-zero inputs.
  always_comb begin
    inexact_d = guard | sticky;
    if (is_nan)                      inexact_d = 1'b0;
    else if (zero_op || underflow)   inexact_d = !zero_op;
    else if (inf_op || overflow)     inexact_d = !inf_op;
  end

  // Inexact register, updated alongside res.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  inexact_q <= 1'b0;
    else if (state_q == ROUND) inexact_q <= inexact_d;
  end

  assign inexact = inexact_q;
`endif

  assign in_ready     = (state_q == IDLE);
  assign out_valid    = out_valid_q;
  assign res          = res_q;
  assign exp_overflow = ovf_q;
  assign nan          = nan_q;
  assign zero         = zero_q;

endmodule

// File: doc/fp_mul_seq.md
Name: fp_mul_seq

Overview:
- Sequential IEEE-754 single-precision multiplier. It is the inverse-operation companion to the combinational divider in the FPU.
- Computes the 24x24 mantissa product with an iterative shift-add datapath under an FSM, then normalises and rounds to nearest even.
- Reports the same exception flags as the divider: exp_overflow, nan, zero.
- Sits behind a valid/ready handshake so the FPU issue logic can stall on it.

Parameters:
- BITS_PER_CYCLE, 1: multiplier bits consumed per MUL cycle. Legal values 1, 2, 3, 4, 6, 8, 12, 24. N = 24/BITS_PER_CYCLE.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands; equals (state==IDLE).
- opd1  in  32  multiplicand, IEEE-754 single.
- opd2  in  32  multiplier, IEEE-754 single.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- res  out  32  product.
- exp_overflow  out  1  result overflowed, or an operand was infinite.
- nan  out  1  result is NaN.
- zero  out  1  result is zero, or underflowed.

Behaviour:
- Reset state: state=IDLE, out_valid=0, res=0, exp_overflow=0, nan=0, zero=0, in_ready=1. Reset mid-operation aborts; the operation produces no output.
- FSM states: IDLE, MUL, ROUND, DONE.
  - IDLE: on in_valid & in_ready, register opd1 and opd2, clear the accumulator, go to MUL.
  - MUL: exactly N cycles; each cycle adds the shifted multiplicand for BITS_PER_CYCLE multiplier bits. Then go to ROUND.
  - ROUND: 1 cycle; normalise, round, classify, register outputs; go to DONE.
  - DONE: out_valid=1. res and flags are held stable until out_ready=1. On that edge out_valid clears and the FSM returns to IDLE.
- Fixed latency for every operand, special cases included: out_valid rises on the (N+2)th rising edge after the accepting edge (26 edges for BITS_PER_CYCLE=1).
- in_ready=0 in MUL, ROUND and DONE. No accept in the same cycle as the output handshake.
- Operand handling: a mantissa with hidden 1 is {1,mant}. Operands with exp=0 are zero; denormals are flushed to zero.
- Exponent: 10-bit signed, e = exp1 + exp2 - 127.
- Normalisation of the 48-bit product P:
  - If P[47]=1: e+1, mantissa P[46:24], guard P[23], sticky |P[22:0].
  - Otherwise: mantissa P[45:23], guard P[22], sticky |P[21:0].
- Rounding is RNE: increment when guard & (sticky | lsb). A mantissa carry-out gives mantissa=0, e+1.
- Exception priority, highest first:
  1. nan: either operand is NaN (exp=255, mant!=0), or 0 x inf. Output res=0x7F800001, nan=1.
  2. zero: either operand is zero (non-NaN partner, not inf), or final e <= 0. Output res=0x00000000 (positive zero), zero=1.
  3. exp_overflow: either operand is inf, or final e >= 255. Output res={sign,8'hFF,23'h0}, exp_overflow=1.
  4. Otherwise: res={sign,e[7:0],mantissa}, all flags 0.
- Sign is opd1[31]^opd2[31], except for the NaN and zero outputs, which force sign 0.
- Exactly one flag at most is high while out_valid=1.
- Flags and res are don't-care-free: they keep their registered values until the next ROUND.

Optional Feature:
- Macro: FP_MUL_INEXACT_EN.
- Defined: adds output port inexact (1 bit, reset 0), registered in ROUND and held with res.
  - inexact=1 when guard|sticky for a normal result.
  - inexact=1 for overflow or underflow that came from finite non-zero operands.
  - inexact=0 for NaN, explicit zero/inf operands and exact results.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Basic product and latency: 0x3FC00000 x 0x40000000, BITS_PER_CYCLE=1 -> res=0x40400000, flags 0, out_valid exactly 26 edges after accept.
- Rounding: 0x3F800001 x 0x3F800001 -> 0x3F800002 (sticky-only, no round). Tie case 0x3F800001 x 0x3FC00000 -> 0x3FC00002 (guard=1, sticky=0, odd lsb, rounds up).
- Overflow and sign: 0x7F000000 x 0x40000000 -> 0x7F800000, exp_overflow=1. 0x7F000000 x 0xC0000000 -> 0xFF800000, exp_overflow=1.
- Zero, underflow and NaN: 0x00800000 x 0x3F000000 -> 0x00000000, zero=1. 0x7F800000 x 0x00000000 -> 0x7F800001, nan=1. 0x7FC00000 x 0x3F800000 -> nan=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> res and flags stable, in_ready=0, in_valid ignored. Releasing out_ready -> in_ready=1 on the next cycle, and a new accept proceeds.
- Reset mid-MUL: assert rst at cycle 10 of MUL -> out_valid=0, res=0, flags 0, in_ready=1 immediately. No stale result after rst deasserts. A subsequent 0x40000000 x 0x40000000 -> 0x40800000.
